// File: rtl/adder_pkg.sv
// Shared types and constants for the pipelined carry-lookahead adder.
package adder_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_ADC = 2'd1,
        OP_SUB = 2'd2,
        OP_SBB = 2'd3
    } op_t;

    localparam int unsigned GRP_W = 4;

    function automatic int unsigned groups_per_stage(input int unsigned width,
                                                     input int unsigned stages);
        return width / (GRP_W * stages);
    endfunction

    function automatic logic is_sub(input op_t op);
        return (op == OP_SUB) || (op == OP_SBB);
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead slice: sum bits plus group propagate/generate.
module cla4_slice
    import adder_pkg::*;
(
    input  logic [GRP_W-1:0] a,
    input  logic [GRP_W-1:0] b,
    input  logic             ci,
    output logic [GRP_W-1:0] s,
    output logic             p,
    output logic             g
);

    logic [GRP_W-1:0] pb;
    logic [GRP_W-1:0] gb;
    logic [GRP_W-1:0] c;

    assign pb = a ^ b;
    assign gb = a & b;

    // Bit carries expanded from ci so none depends on another carry.
    assign c[0] = ci;
    assign c[1] = gb[0] | (pb[0] & ci);
    assign c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & ci);
    assign c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
                | (pb[2] & pb[1] & pb[0] & ci);

    assign s = pb ^ c;
    assign p = &pb;
    assign g = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
             | (pb[3] & pb[2] & pb[1] & gb[0]);

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined add/subtract unit: each stage resolves its own slice of 4-bit
// groups with group lookahead and hands its carry to the next stage.
module cla_adder_pipe
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  op_t              op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NG   = WIDTH / GRP_W;
    localparam int unsigned GPS  = groups_per_stage(WIDTH, STAGES);
    localparam int unsigned SW   = GPS * GRP_W;
    localparam int unsigned LAST = STAGES - 1;

    // Per-stage sources (stage 0 sees the ports, later stages the previous register)
    logic [WIDTH-1:0] src_a   [STAGES];
    logic [WIDTH-1:0] src_b   [STAGES];
    logic [WIDTH-1:0] src_sum [STAGES];
    logic [WIDTH-1:0] effb    [STAGES];
    logic [WIDTH-1:0] nsum    [STAGES];
    op_t              src_op  [STAGES];
    logic [STAGES-1:0] src_c;
    logic [STAGES-1:0] src_v;

    // Pipeline registers
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    op_t              op_q  [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] en;
    logic              ovf_q;
    logic              zero_q;

    logic [NG-1:0]    gp;
    logic [NG-1:0]    gg;
    logic [WIDTH-1:0] grp_sum;
    logic             c0;

    // Carry-in selection for the first stage
    always_comb begin
        c0 = 1'b0;
        case (op)
            OP_ADD:  c0 = 1'b0;
            OP_ADC:  c0 = cin;
            OP_SUB:  c0 = 1'b1;
            OP_SBB:  c0 = cin;
            default: c0 = 1'b0;
        endcase
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int unsigned      BASE = s * GPS;
        localparam logic [WIDTH-1:0] MASK = WIDTH'({SW{1'b1}}) << (s * SW);

        logic [GPS:0] cl;

        if (s == 0) begin : g_src_in
            assign src_a[s]   = A;
            assign src_b[s]   = B;
            assign src_op[s]  = op;
            assign src_c[s]   = c0;
            assign src_sum[s] = '0;
            assign src_v[s]   = in_valid;
        end else begin : g_src_reg
            assign src_a[s]   = a_q[s-1];
            assign src_b[s]   = b_q[s-1];
            assign src_op[s]  = op_q[s-1];
            assign src_c[s]   = c_q[s-1];
            assign src_sum[s] = sum_q[s-1];
            assign src_v[s]   = v_q[s-1];
        end

        assign effb[s] = is_sub(src_op[s]) ? ~src_b[s] : src_b[s];
        assign cl[0]   = src_c[s];

        // Group carries as flat sums of products over group P/G
        for (genvar j = 1; j <= GPS; j++) begin : g_la
            logic [j:0] t;
            assign t[0] = src_c[s] & (&gp[BASE +: j]);
            for (genvar k = 0; k < j; k++) begin : g_term
                if (k == j - 1) begin : g_near
                    assign t[k+1] = gg[BASE+k];
                end else begin : g_far
                    assign t[k+1] = gg[BASE+k] & (&gp[BASE+k+1 +: j-k-1]);
                end
            end
            assign cl[j] = |t;
        end

        for (genvar j = 0; j < GPS; j++) begin : g_grp
            cla4_slice u_slice (
                .a  (src_a[s][GRP_W*(BASE+j) +: GRP_W]),
                .b  (effb[s][GRP_W*(BASE+j) +: GRP_W]),
                .ci (cl[j]),
                .s  (grp_sum[GRP_W*(BASE+j) +: GRP_W]),
                .p  (gp[BASE+j]),
                .g  (gg[BASE+j])
            );
        end

        assign nsum[s] = src_sum[s] | (grp_sum & MASK);

        // Stage loads when it or any stage downstream of it has room
        assign en[s] = out_ready | ~(&v_q[LAST:s]);

        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                v_q[s]   <= 1'b0;
                a_q[s]   <= '0;
                b_q[s]   <= '0;
                op_q[s]  <= OP_ADD;
                c_q[s]   <= 1'b0;
                sum_q[s] <= '0;
            end else if (en[s]) begin
                v_q[s] <= src_v[s];
                if (src_v[s]) begin
                    a_q[s]   <= src_a[s];
                    b_q[s]   <= src_b[s];
                    op_q[s]  <= src_op[s];
                    c_q[s]   <= cl[GPS];
                    sum_q[s] <= nsum[s];
                end
            end
        end

        if (s == LAST) begin : g_flags
            logic ovf_d;
            logic zero_d;

            assign ovf_d  = (src_a[s][WIDTH-1] == effb[s][WIDTH-1])
                         && (nsum[s][WIDTH-1] != src_a[s][WIDTH-1]);
            assign zero_d = (nsum[s] == '0);

            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (en[s] && src_v[s]) begin
                    ovf_q  <= ovf_d;
                    zero_q <= zero_d;
                end
            end
        end
    end

    assign in_ready  = en[0];
    assign out_valid = v_q[LAST];
    assign S         = sum_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
